// File: rtl/button_event_arbiter_if.sv
// Event stream between the button arbiter and its consumer.
// The producer holds evt_id/evt_kind stable while evt_valid is high and evt_ready is low.
interface button_event_arbiter_if #(
    parameter int unsigned IDW = 2
);
    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;
    logic [1:0]     evt_kind;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_kind,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_kind,
        output evt_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Button event arbiter: turns N debounced button levels into discrete PRESS/LONG/REPEAT/RELEASE
// events, buffers one pending event per button and round-robins them onto one valid/ready stream.
// Events that arrive while a button's slot is still full are dropped and flagged in overflow.
module button_event_arbiter #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned IDW           = 2,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_level,
    input  logic [N_BTN-1:0]       repeat_en,
    button_event_arbiter_if.master evt,
    output logic [N_BTN-1:0]       overflow,
    input  logic [N_BTN-1:0]       clr_overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StHeld
    } btn_state_e;

    typedef enum logic [1:0] {
        KindPress   = 2'b00,
        KindLong    = 2'b01,
        KindRepeat  = 2'b10,
        KindRelease = 2'b11
    } evt_kind_e;

    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

    // Reject parameter sets the id encoding or the timers cannot support.
    if (N_BTN < 2 || N_BTN > 8 || (1 << IDW) < N_BTN ||
        HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("button_event_arbiter: unsupported parameter combination");
    end

    // Per-button classifier state
    btn_state_e       state_q [N_BTN];
    btn_state_e       state_d [N_BTN];
    logic [CNT_W-1:0] timer_q [N_BTN];
    logic [CNT_W-1:0] timer_d [N_BTN];
    logic [N_BTN-1:0] gen_valid;
    evt_kind_e        gen_kind [N_BTN];

    // Pending slots and overflow flags
    logic [N_BTN-1:0] slot_valid_q, slot_valid_d;
    evt_kind_e        slot_kind_q [N_BTN];
    evt_kind_e        slot_kind_d [N_BTN];
    logic [N_BTN-1:0] overflow_q, overflow_d;
    logic [N_BTN-1:0] drop;

    // Arbitration and output register
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             load;
    logic             found;
    logic [IDW-1:0]   win_id;
    logic [N_BTN-1:0] grant;
    logic             out_valid_q, out_valid_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    evt_kind_e        out_kind_q, out_kind_d;

    // Classify each button's level history and decide which event, if any, it raises this edge.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            timer_d[i]   = timer_q[i];
            gen_valid[i] = 1'b0;
            gen_kind[i]  = KindPress;
            case (state_q[i])
                StIdle: begin
                    if (btn_level[i]) begin
                        state_d[i]   = StPressed;
                        timer_d[i]   = '0;
                        gen_valid[i] = 1'b1;
                        gen_kind[i]  = KindPress;
                    end
                end
                StPressed: begin
                    if (!btn_level[i]) begin
                        state_d[i]   = StIdle;
                        timer_d[i]   = '0;
                        gen_valid[i] = 1'b1;
                        gen_kind[i]  = KindRelease;
                    end else if (timer_q[i] == HoldLast) begin
                        state_d[i]   = StHeld;
                        timer_d[i]   = '0;
                        gen_valid[i] = 1'b1;
                        gen_kind[i]  = KindLong;
                    end else begin
                        timer_d[i] = timer_q[i] + CNT_W'(1);
                    end
                end
                StHeld: begin
                    if (!btn_level[i]) begin
                        state_d[i]   = StIdle;
                        timer_d[i]   = '0;
                        gen_valid[i] = 1'b1;
                        gen_kind[i]  = KindRelease;
                    end else if (!repeat_en[i]) begin
                        // Repeat disabled: park the timer so re-enabling starts a full period.
                        timer_d[i] = '0;
                    end else if (timer_q[i] == RepeatLast) begin
                        timer_d[i]   = '0;
                        gen_valid[i] = 1'b1;
                        gen_kind[i]  = KindRepeat;
                    end else begin
                        timer_d[i] = timer_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // Register per-button FSM state and hold/repeat timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= StIdle;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Round-robin search over the registered slots, starting at ptr and wrapping.
    always_comb begin
        logic [IDW:0] idx;
        idx    = '0;
        found  = 1'b0;
        win_id = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(N_BTN)) begin
                idx = idx - (IDW + 1)'(N_BTN);
            end
            if (!found && slot_valid_q[idx[IDW-1:0]]) begin
                found  = 1'b1;
                win_id = idx[IDW-1:0];
            end
        end
    end

    // Output register is free when empty or being accepted this edge.
    always_comb begin
        load  = !out_valid_q || evt.evt_ready;
        grant = '0;
        if (load && found) begin
            grant[win_id] = 1'b1;
        end
    end

    // Slot update: a new event replaces a slot being granted, otherwise a full slot drops it.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            slot_valid_d[i] = slot_valid_q[i];
            slot_kind_d[i]  = slot_kind_q[i];
            drop[i]         = 1'b0;
            if (gen_valid[i]) begin
                if (slot_valid_q[i] && !grant[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    slot_valid_d[i] = 1'b1;
                    slot_kind_d[i]  = gen_kind[i];
                end
            end else if (grant[i]) begin
                slot_valid_d[i] = 1'b0;
            end
        end
        // A drop in the same cycle as a clear must stay visible.
        overflow_d = (overflow_q & ~clr_overflow) | drop;
    end

    // Register pending slots and sticky overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            overflow_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                slot_kind_q[i] <= KindPress;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < N_BTN; i++) begin
                slot_kind_q[i] <= slot_kind_d[i];
            end
        end
    end

    // Load the winner into the output register and advance the priority pointer past it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_kind_d  = out_kind_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_id_d   = win_id;
                out_kind_d = slot_kind_q[win_id];
                ptr_d      = (win_id == IDW'(N_BTN - 1)) ? '0 : win_id + IDW'(1);
            end
        end
    end

    // Register the event stream output and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_kind_q  <= KindPress;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_kind_q  <= out_kind_d;
            ptr_q       <= ptr_d;
        end
    end

    assign evt.evt_valid = out_valid_q;
    assign evt.evt_id    = out_id_q;
    assign evt.evt_kind  = out_kind_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with short hold/repeat periods.
module tb_button_event_arbiter;

    localparam int unsigned N_BTN = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned REP   = 4;

    localparam int K_PRESS   = 0;
    localparam int K_LONG    = 1;
    localparam int K_REPEAT  = 2;
    localparam int K_RELEASE = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] repeat_en;
    logic [N_BTN-1:0] overflow;
    logic [N_BTN-1:0] clr_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int q_id[$];
    int q_kind[$];
    int q_cyc[$];

    button_event_arbiter_if #(.IDW(IDW)) evt_if ();

    button_event_arbiter #(
        .N_BTN(N_BTN),
        .IDW(IDW),
        .CNT_W(CNT_W),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_level(btn_level),
        .repeat_en(repeat_en),
        .evt(evt_if.master),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted event; inputs settle 1 time unit after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            q_id.push_back(int'(evt_if.evt_id));
            q_kind.push_back(int'(evt_if.evt_kind));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_events(input int n);
        int budget = 40;
        while (q_id.size() < n && budget > 0) begin
            tick();
            budget--;
        end
    endtask

    task automatic clear_log();
        q_id.delete();
        q_kind.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_level = '0;
        repeat_en = '0;
        clr_overflow = '0;
        evt_if.evt_ready = 1'b1;
        #12;
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== 5'b0)
            $display("FAIL reset_out: got %b required 00000",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        n_checks++;
        if (overflow !== 4'b0000) $display("FAIL reset_ovf: got %b required 0000", overflow);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL idle_valid: got %b required 0", evt_if.evt_valid);
        else n_pass++;
    endtask

    task automatic test_press_release();
        clear_log();
        btn_level[2] = 1'b1;
        tick();
        n_checks++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL lat_e0: got %b required 0", evt_if.evt_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== {1'b1, 2'd2, 2'd0})
            $display("FAIL lat_e1: got %b required 11000",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        tick();
        btn_level[2] = 1'b0;
        wait_events(2);
        repeat (12) tick();
        n_checks++;
        if (q_id.size() != 2) $display("FAIL pr_count: got %0d required 2", q_id.size());
        else n_pass++;
        n_checks++;
        if (q_id.size() < 2 || q_id[1] != 2 || q_kind[1] != K_RELEASE)
            $display("FAIL pr_release: got size %0d required id 2 kind 3", q_id.size());
        else n_pass++;
        n_checks++;
        if (q_cyc.size() < 2 || q_cyc[1] - q_cyc[0] != 3)
            $display("FAIL pr_spacing: got size %0d required delta 3", q_cyc.size());
        else n_pass++;
        n_checks++;
        if (overflow !== 4'b0000) $display("FAIL pr_ovf: got %b required 0000", overflow);
        else n_pass++;
    endtask

    task automatic test_long_repeat();
        int exp_kind[5] = '{K_PRESS, K_LONG, K_REPEAT, K_REPEAT, K_RELEASE};
        int exp_dt[5]   = '{0, 8, 12, 16, 20};
        clear_log();
        repeat_en[1] = 1'b1;
        btn_level[1] = 1'b1;
        repeat (20) tick();
        btn_level[1] = 1'b0;
        wait_events(5);
        repeat (10) tick();
        n_checks++;
        if (q_id.size() != 5) $display("FAIL lr_count: got %0d required 5", q_id.size());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= q_id.size() || q_id[i] != 1 || q_kind[i] != exp_kind[i])
                $display("FAIL lr_evt%0d: got size %0d required id 1 kind %0d",
                         i, q_id.size(), exp_kind[i]);
            else n_pass++;
            n_checks++;
            if (i >= q_cyc.size() || q_cyc[i] - q_cyc[0] != exp_dt[i])
                $display("FAIL lr_time%0d: got size %0d required delta %0d",
                         i, q_cyc.size(), exp_dt[i]);
            else n_pass++;
        end
        repeat_en[1] = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_id[3] = '{0, 1, 3};
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        clear_log();
        evt_if.evt_ready = 1'b0;
        btn_level = 4'b1011;
        tick();
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id} !== 3'b100)
            $display("FAIL rr_first: got %b required 100", {evt_if.evt_valid, evt_if.evt_id});
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== 5'b10000)
            $display("FAIL rr_hold: got %b required 10000",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        evt_if.evt_ready = 1'b1;
        wait_events(3);
        tick();
        n_checks++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL rr_drain: got %b required 0", evt_if.evt_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= q_id.size() || q_id[i] != exp_id[i] || q_kind[i] != K_PRESS)
                $display("FAIL rr_press%0d: got size %0d required id %0d", i, q_id.size(), exp_id[i]);
            else n_pass++;
        end
        clear_log();
        btn_level = '0;
        wait_events(3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= q_id.size() || q_id[i] != exp_id[i] || q_kind[i] != K_RELEASE)
                $display("FAIL rr_rel%0d: got size %0d required id %0d", i, q_id.size(), exp_id[i]);
            else n_pass++;
        end
        n_checks++;
        if (q_cyc.size() < 3 || q_cyc[2] - q_cyc[0] != 2)
            $display("FAIL rr_rate: got size %0d required delta 2", q_cyc.size());
        else n_pass++;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        clear_log();
        evt_if.evt_ready = 1'b0;
        btn_level[0] = 1'b1;
        tick();
        btn_level[0] = 1'b0;
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind, overflow} !== 9'b1_00_00_0000)
            $display("FAIL bp_first: got %b required 100000000",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind, overflow});
        else n_pass++;
        btn_level[0] = 1'b1;
        tick();
        btn_level[0] = 1'b0;
        tick();
        n_checks++;
        if (overflow !== 4'b0001) $display("FAIL bp_ovf: got %b required 0001", overflow);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== 5'b10000)
            $display("FAIL bp_stable: got %b required 10000",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        clr_overflow[0] = 1'b1;
        tick();
        clr_overflow[0] = 1'b0;
        n_checks++;
        if (overflow !== 4'b0000) $display("FAIL bp_clear: got %b required 0000", overflow);
        else n_pass++;
        btn_level[0] = 1'b1;
        clr_overflow[0] = 1'b1;
        tick();
        clr_overflow[0] = 1'b0;
        n_checks++;
        if (overflow !== 4'b0001) $display("FAIL bp_setwins: got %b required 0001", overflow);
        else n_pass++;
        btn_level[0] = 1'b0;
        tick();
        evt_if.evt_ready = 1'b1;
        wait_events(2);
        repeat (4) tick();
        n_checks++;
        if (q_id.size() != 2 || q_id[0] != 0 || q_kind[0] != K_PRESS ||
            q_id[1] != 0 || q_kind[1] != K_RELEASE)
            $display("FAIL bp_drain: got size %0d required PRESS then RELEASE on id 0", q_id.size());
        else n_pass++;
        n_checks++;
        if (overflow !== 4'b0001) $display("FAIL bp_sticky: got %b required 0001", overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        evt_if.evt_ready = 1'b0;
        btn_level[3] = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id} !== 3'b111)
            $display("FAIL rm_pre: got %b required 111", {evt_if.evt_valid, evt_if.evt_id});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({evt_if.evt_valid, overflow} !== 5'b0)
            $display("FAIL rm_async: got %b required 00000", {evt_if.evt_valid, overflow});
        else n_pass++;
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick();
        n_checks++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL rm_e0: got %b required 0", evt_if.evt_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== 5'b11100)
            $display("FAIL rm_e1: got %b required 11100",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        btn_level[3] = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_same_edge();
        clear_log();
        evt_if.evt_ready = 1'b1;
        btn_level[2] = 1'b1;
        tick();
        btn_level[2] = 1'b0;
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== 5'b11000)
            $display("FAIL se_press: got %b required 11000",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        tick();
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind} !== 5'b11011)
            $display("FAIL se_release: got %b required 11011",
                     {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind});
        else n_pass++;
        wait_events(2);
        repeat (3) tick();
        n_checks++;
        if (q_id.size() != 2 || overflow !== 4'b0000)
            $display("FAIL se_noovf: got size %0d ovf %b required size 2 ovf 0000",
                     q_id.size(), overflow);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_long_repeat();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_same_edge();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
